vmem_access_unit: RTL and testbench

- Request sequencer that sits directly upstream of the vector data memory, a single-port synchronous RAM with 1-cycle read latency.
- Accepts one strided vector load or store per handshake and drives one memory element access per cycle.
- For loads, collects the returned words into a lane buffer and presents the whole vector on a response channel with a valid/ready handshake.

---
 rtl/vmem_access_unit.sv | 86 ++++++++
 tb/tb_vmem_access_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vmem_access_unit.sv
// vmem_access_unit: strided vector load/store sequencer in front of a 1-cycle-latency single-port RAM
// Ports: req_* accepts one vector request per handshake; resp_* returns the gathered vector (or a
// store acknowledge); mem_* drives one element access per cycle, with mem_rddata arriving the cycle
// after its address.
module vmem_access_unit #(
  parameter int MEMORY_BITS = 32,
  parameter int ADDR_RANGE = 32768,
  parameter int VECTOR_LANES = 8,
  localparam int AW = $clog2(ADDR_RANGE),
  localparam int CW = $clog2(VECTOR_LANES) + 1,
  localparam int LW = $clog2(VECTOR_LANES)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_is_store,
  input  logic [AW-1:0]                     req_base,
  input  logic [AW-1:0]                     req_stride,
  input  logic [CW-1:0]                     req_count,
  input  logic [VECTOR_LANES*MEMORY_BITS-1:0] req_wdata,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic                              resp_is_store,
  output logic [VECTOR_LANES*MEMORY_BITS-1:0] resp_rdata,
  output logic                              mem_we,
  output logic [AW-1:0]                     mem_address,
  output logic [MEMORY_BITS-1:0]            mem_data_in,
  input  logic [MEMORY_BITS-1:0]            mem_rddata
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
  state_t state;
  logic is_store, pend_v;
  logic [AW-1:0] stride, cur_addr;
  logic [CW-1:0] cnt, idx;
  logic [LW-1:0] pend;
  logic [VECTOR_LANES*MEMORY_BITS-1:0] wdata, buf_q;
  logic [CW-1:0] cnt_in;
  assign cnt_in = req_count > CW'(VECTOR_LANES) ? CW'(VECTOR_LANES) : req_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      is_store <= 1'b0;
      stride <= '0;
      cur_addr <= '0;
      cnt <= '0;
      idx <= '0;
      wdata <= '0;
      buf_q <= '0;
      pend <= '0;
      pend_v <= 1'b0;
    end else begin
      pend_v <= state == ISSUE && !is_store;
      pend <= idx[LW-1:0];
      if (pend_v) buf_q[pend*MEMORY_BITS +: MEMORY_BITS] <= mem_rddata;
      case (state)
        IDLE: if (req_valid) begin
          is_store <= req_is_store;
          stride <= req_stride;
          cur_addr <= req_base;
          cnt <= cnt_in;
          idx <= '0;
          wdata <= req_wdata;
          buf_q <= '0;
          // an empty request still spends one edge in DRAIN so its response follows one edge later
          state <= cnt_in == '0 ? DRAIN : ISSUE;
        end
        ISSUE: begin
          idx <= idx + CW'(1);
          cur_addr <= cur_addr + stride;
          if (idx == cnt - CW'(1)) state <= is_store ? RESP : DRAIN;
        end
        DRAIN: state <= RESP;
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_is_store = resp_valid & is_store;
  assign resp_rdata = buf_q;
  assign mem_we = state == ISSUE && is_store;
  assign mem_address = state == ISSUE ? cur_addr : '0;
  assign mem_data_in = mem_we ? wdata[idx[LW-1:0]*MEMORY_BITS +: MEMORY_BITS] : '0;
endmodule

// File: tb/tb_vmem_access_unit.sv
// tb_vmem_access_unit: directed self-checking bench for vmem_access_unit with a behavioural RAM
module tb_vmem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [14:0] req_base = '0, req_stride = '0;
  logic [3:0] req_count = '0;
  logic [255:0] req_wdata = '0;
  logic resp_valid, resp_ready = 1'b1, resp_is_store;
  logic [255:0] resp_rdata;
  logic mem_we;
  logic [14:0] mem_address;
  logic [31:0] mem_data_in, mem_rddata;
  logic [31:0] mem [32768];
  int n_checks = 0, n_fail = 0, lat, we_n;
  logic [14:0] addr_q[$];
  logic [31:0] data_q[$];
  logic [255:0] e, held;
  vmem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_base(req_base), .req_stride(req_stride),
    .req_count(req_count), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_is_store(resp_is_store), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_rddata(mem_rddata)
  );
  always #5 clk = ~clk;
  always begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h1000 + i;
    mem_rddata = '0;
    forever begin
      @(posedge clk);
      mem_rddata <= mem[mem_address];
      if (mem_we) mem[mem_address] = mem_data_in;
    end
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input logic st, input logic [14:0] base, input logic [14:0] stride,
                        input logic [3:0] cnt, input logic [255:0] wd);
    int guard;
    addr_q.delete();
    data_q.delete();
    we_n = 0;
    lat = 0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      step();
      guard++;
    end
    req_valid = 1'b1;
    req_is_store = st;
    req_base = base;
    req_stride = stride;
    req_count = cnt;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 40) begin
      if (addr_q.size() < 32'(cnt)) addr_q.push_back(mem_address);
      if (mem_we) begin
        we_n++;
        data_q.push_back(mem_data_in);
      end
      step();
      lat++;
      guard++;
    end
    if (!resp_valid) chk("resp_timeout", 0, 1);
  endtask
  task automatic chk_addrs(input string tag, input logic [14:0] base, input logic [14:0] stride, input int cnt);
    logic [14:0] ea;
    ea = base;
    chk({tag, "_naddr"}, addr_q.size(), cnt);
    for (int k = 0; k < cnt && k < addr_q.size(); k++) begin
      chk({tag, "_addr"}, addr_q[k], ea);
      ea = ea + stride;
    end
  endtask
  initial begin
    repeat (3) step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_is_store", resp_is_store, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    rst_n = 1'b1;
    step();
    do_req(0, 15'd4, 15'd1, 4'd8, '0);
    chk("ld8_lat", lat, 9);
    chk("ld8_we", we_n, 0);
    chk_addrs("ld8", 15'd4, 15'd1, 8);
    for (int i = 0; i < 8; i++) e[i*32 +: 32] = 32'h1004 + i;
    chk("ld8_rdata", resp_rdata, e);
    chk("ld8_is_store", resp_is_store, 0);
    e = {128'h0, 32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    do_req(1, 15'd100, 15'd3, 4'd4, e);
    chk("st4_lat", lat, 4);
    chk("st4_we", we_n, 4);
    chk_addrs("st4", 15'd100, 15'd3, 4);
    for (int k = 0; k < data_q.size(); k++) chk("st4_wdata", data_q[k], e[k*32 +: 32]);
    chk("st4_is_store", resp_is_store, 1);
    chk("st4_rdata", resp_rdata, 0);
    do_req(0, 15'd100, 15'd3, 4'd4, '0);
    chk("st4_readback", resp_rdata, e);
    do_req(0, 15'd32766, 15'd1, 4'd4, '0);
    chk_addrs("wrap_up", 15'd32766, 15'd1, 4);
    chk("wrap_up_rdata", resp_rdata, {128'h0, 32'h1001, 32'h1000, 32'h8FFF, 32'h8FFE});
    do_req(0, 15'd1, 15'h7FFF, 4'd3, '0);
    chk_addrs("wrap_dn", 15'd1, 15'h7FFF, 3);
    chk("wrap_dn_lat", lat, 4);
    chk("wrap_dn_rdata", resp_rdata, {160'h0, 32'h8FFF, 32'h1000, 32'h1001});
    do_req(0, 15'd50, 15'd1, 4'd0, '0);
    chk("cnt0_lat", lat, 1);
    chk("cnt0_naddr", addr_q.size(), 0);
    chk("cnt0_rdata", resp_rdata, 0);
    do_req(0, 15'd0, 15'd2, 4'd3, '0);
    chk("cnt3_rdata", resp_rdata, {160'h0, 32'h1004, 32'h1002, 32'h1000});
    do_req(0, 15'd0, 15'd1, 4'd12, '0);
    chk("clamp_lat", lat, 9);
    for (int i = 0; i < 8; i++) e[i*32 +: 32] = 32'h1000 + i;
    chk("clamp_rdata", resp_rdata, e);
    do_req(1, 15'd200, 15'd0, 4'd3, {160'h0, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000});
    chk("s0_we", we_n, 3);
    chk_addrs("s0", 15'd200, 15'd0, 3);
    chk("s0_mem", mem[200], 32'h3333_0000);
    do_req(0, 15'd200, 15'd0, 4'd4, '0);
    chk("s0_ld_rdata", resp_rdata, {128'h0, {4{32'h3333_0000}}});
    step();
    resp_ready = 1'b0;
    do_req(0, 15'd8, 15'd1, 4'd2, '0);
    held = resp_rdata;
    chk("hold_rdata0", held, {192'h0, 32'h1009, 32'h1008});
    req_valid = 1'b1;
    req_is_store = 1'b0;
    req_count = 4'd0;
    for (int k = 0; k < 5; k++) begin
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, held);
      chk("hold_req_ready", req_ready, 0);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("hs_req_ready", req_ready, 1);
    chk("hs_resp_valid", resp_valid, 0);
    step();
    req_valid = 1'b0;
    chk("pend_accepted", req_ready, 0);
    step();
    chk("pend_resp_valid", resp_valid, 1);
    chk("pend_rdata", resp_rdata, 0);
    step();
    e = {32'h7777_0008, 32'h7777_0007, 32'h7777_0006, 32'h7777_0005,
         32'h7777_0004, 32'h7777_0003, 32'h7777_0002, 32'h7777_0001};
    req_valid = 1'b1;
    req_is_store = 1'b1;
    req_base = 15'd300;
    req_stride = 15'd1;
    req_count = 4'd8;
    req_wdata = e;
    step();
    req_valid = 1'b0;
    chk("abort_addr0", mem_address, 300);
    step();
    chk("abort_addr1", mem_address, 301);
    step();
    chk("abort_we2", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_async", mem_we, 0);
    chk("abort_addr_async", mem_address, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("abort_resp_valid", resp_valid, 0);
      chk("abort_req_ready", req_ready, 1);
      step();
    end
    chk("abort_mem300", mem[300], e[31:0]);
    chk("abort_mem301", mem[301], e[63:32]);
    chk("abort_mem302", mem[302], 32'h1000 + 302);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
